load_store_unit: RTL and testbench

Multi-cycle load/store unit sitting between the CPU datapath and the word-wide data memory; it is the initiator end of the memory's addr/data/read/write interface. It accepts one byte, halfword or word access from the core, drives the memory's read and write strobes, and builds sub-word stores as read-modify-write sequences. Loads are sign- or zero-extended, and misaligned or out-of-range accesses are rejected without touching memory.

---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 118 +++++++++++
 tb/tb_load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// The slave modport is the unit itself; master is whoever drives the core and models memory.
interface load_store_unit_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        ack_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_data_i;

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_data_i,
    output busy_o, ack_o, err_o, rdata_o, mem_addr_o, mem_data_o, mem_read_o, mem_write_o
  );

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_data_i,
    input  busy_o, ack_o, err_o, rdata_o, mem_addr_o, mem_data_o, mem_read_o, mem_write_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: byte/half/word accesses to a word-wide memory,
// sub-word stores as read-modify-write, sign/zero-extended loads, error rejection.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic               clk_i,
  input logic               rst_i,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q, unsigned_q, err_q;
  logic [1:0]  size_q, offset_q;
  logic [15:0] wdata_q;
  logic [31:0] mem_addr_q, mem_data_q, rdata_q;

  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext, merged;

  // Request check uses a 33-bit sum so addresses near 2^32 cannot wrap into range.
  always_comb begin
    unique case (bus.size_i)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    end_addr = {1'b0, bus.addr_i} + 33'(nbytes);
    req_err  = (bus.size_i == 2'b11) ||
               (bus.size_i == 2'b01 && bus.addr_i[0]) ||
               (bus.size_i == 2'b10 && bus.addr_i[1:0] != 2'b00) ||
               (end_addr > 33'(MEM_BYTES));
  end

  always_comb begin
    lane_b = bus.mem_data_i[{offset_q, 3'b000} +: 8];
    lane_h = bus.mem_data_i[{offset_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = unsigned_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = bus.mem_data_i;
    endcase
  end

  always_comb begin
    merged = bus.mem_data_i;
    if (size_q == 2'b00) merged[{offset_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{offset_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_i) begin
          if (req_err)                            state_d = StDone;
          else if (bus.we_i && bus.size_i == 2'b10) state_d = StWrite;
          else                                    state_d = StRead;
        end
      end
      StRead:  state_d = we_q ? StWrite : StDone;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      offset_q   <= 2'b00;
      wdata_q    <= 16'h0;
      mem_addr_q <= 32'h0;
      mem_data_q <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (bus.req_i) begin
            we_q       <= bus.we_i;
            size_q     <= bus.size_i;
            unsigned_q <= bus.unsigned_i;
            wdata_q    <= bus.wdata_i[15:0];
            offset_q   <= bus.addr_i[1:0];
            mem_addr_q <= {bus.addr_i[31:2], 2'b00};
            err_q      <= req_err;
            if (!req_err && bus.we_i && bus.size_i == 2'b10) mem_data_q <= bus.wdata_i;
          end
        end
        StRead: begin
          if (we_q) mem_data_q <= merged;
          else      rdata_q    <= load_ext;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o      = (state_q != StIdle);
  assign bus.ack_o       = (state_q == StDone);
  assign bus.err_o       = (state_q == StDone) && err_q;
  assign bus.mem_read_o  = (state_q == StRead);
  assign bus.mem_write_o = (state_q == StWrite);
  assign bus.rdata_o     = rdata_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random accesses checked against
// a byte-array memory model.
module tb_load_store_unit;
  localparam int unsigned MemBytes = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(MemBytes)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  logic [7:0]  ref_bytes [MemBytes];
  logic [31:0] model_rdata;

  assign bus.mem_data_i = bus.mem_read_o ? mem[bus.mem_addr_o[9:2]] : 32'h0;
  always @(posedge clk) if (bus.mem_write_o) mem[bus.mem_addr_o[9:2]] = bus.mem_data_o;

  int checks = 0;
  int errors = 0;
  int rd_cnt, wr_cnt, ack_cnt, both_cnt;

  always @(negedge clk) begin
    if (bus.mem_read_o) rd_cnt++;
    if (bus.mem_write_o) wr_cnt++;
    if (bus.ack_o) ack_cnt++;
    if (bus.mem_read_o && bus.mem_write_o) both_cnt++;
  end

  logic [31:0] got_rdata, exp_rdata;
  logic        got_err, exp_err;
  int          got_lat, exp_lat, exp_rd, exp_wr;

  function automatic bit f_err(logic [1:0] size, logic [31:0] addr);
    longint e = longint'(addr) + (longint'(1) << size);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) || (e > longint'(MemBytes));
  endfunction

  function automatic logic [31:0] f_load(logic [1:0] size, logic uns, logic [31:0] addr);
    longint v = 0;
    int n = 1 << size;
    for (int i = 0; i < n; i++) v += longint'(ref_bytes[addr + i]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  // Drives one access, waits for its ack, and computes the model's expectations.
  task automatic run(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    int n;
    exp_err = f_err(size, addr);
    n = 1 << size;
    if (!exp_err && !we) model_rdata = f_load(size, uns, addr);
    if (!exp_err && we)
      for (int i = 0; i < n; i++) ref_bytes[addr + i] = 8'(wdata >> (8 * i));
    exp_rdata = model_rdata;
    exp_lat = exp_err ? 1 : (!we || size == 2'b10) ? 2 : 3;
    exp_rd  = (!exp_err && (!we || size != 2'b10)) ? 1 : 0;
    exp_wr  = (!exp_err && we) ? 1 : 0;

    @(posedge clk); #1;
    rd_cnt = 0; wr_cnt = 0; ack_cnt = 0;
    bus.req_i = 1'b1; bus.we_i = we; bus.size_i = size; bus.unsigned_i = uns;
    bus.addr_i = addr; bus.wdata_i = wdata;
    @(posedge clk); #1;
    if (!hold) bus.req_i = 1'b0;
    got_lat = 0; got_rdata = 32'h0; got_err = 1'b0;
    while (got_lat < 8) begin
      @(negedge clk);
      got_lat++;
      if (bus.ack_o) begin
        got_rdata = bus.rdata_o;
        got_err = bus.err_o;
        break;
      end
    end
    if (!bus.ack_o) got_lat = 99;
    bus.req_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus.busy_o, bus.ack_o, bus.err_o, bus.mem_read_o, bus.mem_write_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 00000",
               {bus.busy_o, bus.ack_o, bus.err_o, bus.mem_read_o, bus.mem_write_o});
    end
    checks++;
    if ({bus.rdata_o, bus.mem_addr_o, bus.mem_data_o} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h want 0", bus.rdata_o, bus.mem_addr_o,
               bus.mem_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'h0;
  endtask

  task automatic test_word();
    run(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    checks++;
    if (got_lat !== 2 || got_err !== 1'b0 || wr_cnt !== 1 || rd_cnt !== 0) begin
      errors++;
      $display("FAIL sw got lat=%0d err=%b wr=%0d rd=%0d want 2 0 1 0", got_lat, got_err,
               wr_cnt, rd_cnt);
    end
    run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    checks++;
    if (got_rdata !== 32'hDEADBEEF || got_lat !== 2 || got_err !== 1'b0 || rd_cnt !== 1) begin
      errors++;
      $display("FAIL lw got rdata=%h lat=%0d err=%b rd=%0d want deadbeef 2 0 1", got_rdata,
               got_lat, got_err, rd_cnt);
    end
  endtask

  task automatic test_byte_loads();
    logic [1:0]  sz [4]  = '{2'b00, 2'b00, 2'b00, 2'b01};
    logic        un [4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad [4]  = '{32'h23, 32'h23, 32'h21, 32'h22};
    logic [31:0] want [4] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFF80FF};
    run(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run(1'b0, sz[i], un[i], ad[i], 32'h0, 1'b0);
      checks++;
      if (got_rdata !== want[i] || got_rdata !== exp_rdata || got_lat !== 2) begin
        errors++;
        $display("FAIL subload_%0d got rdata=%h lat=%0d want %h 2", i, got_rdata, got_lat,
                 want[i]);
      end
    end
  endtask

  task automatic test_subword_store();
    run(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, 1'b0);
    run(1'b1, 2'b00, 1'b0, 32'h31, 32'h000000AA, 1'b0);
    checks++;
    if (got_lat !== 3 || rd_cnt !== 1 || wr_cnt !== 1 || got_err !== 1'b0) begin
      errors++;
      $display("FAIL sb got lat=%0d rd=%0d wr=%0d err=%b want 3 1 1 0", got_lat, rd_cnt,
               wr_cnt, got_err);
    end
    run(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000BEEF, 1'b0);
    checks++;
    if (got_lat !== 3 || rd_cnt !== 1 || wr_cnt !== 1) begin
      errors++;
      $display("FAIL sh got lat=%0d rd=%0d wr=%0d want 3 1 1", got_lat, rd_cnt, wr_cnt);
    end
    run(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0);
    checks++;
    if (got_rdata !== 32'hBEEFAA44) begin
      errors++;
      $display("FAIL rmw_readback got %h want beefaa44", got_rdata);
    end
  endtask

  task automatic test_errors();
    logic        we [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [7] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01};
    logic [31:0] ad [7] = '{32'h21, 32'h22, 32'h40, 32'h3FE, 32'h21, 32'h400, 32'h3FE};
    bit          bad [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      run(we[i], sz[i], 1'b0, ad[i], 32'h12345678, 1'b0);
      checks++;
      if (bad[i] && (got_err !== 1'b1 || got_lat !== 1 || rd_cnt !== 0 || wr_cnt !== 0 ||
                     got_rdata !== exp_rdata)) begin
        errors++;
        $display("FAIL err_%0d got err=%b lat=%0d rd=%0d wr=%0d rdata=%h want 1 1 0 0 %h", i,
                 got_err, got_lat, rd_cnt, wr_cnt, got_rdata, exp_rdata);
      end else if (!bad[i] && (got_err !== 1'b0 || got_rdata !== exp_rdata)) begin
        errors++;
        $display("FAIL edge_%0d got err=%b rdata=%h want 0 %h", i, got_err, got_rdata,
                 exp_rdata);
      end
    end
  endtask

  task automatic test_busy_hold();
    run(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (ack_cnt !== 1 || bus.busy_o !== 1'b0 || got_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL busy_hold got acks=%0d busy=%b rdata=%h want 1 0 %h", ack_cnt,
               bus.busy_o, got_rdata, exp_rdata);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] want_word;
    want_word = {ref_bytes[32'h33], ref_bytes[32'h32], ref_bytes[32'h31], ref_bytes[32'h30]};
    @(posedge clk); #1;
    ack_cnt = 0; wr_cnt = 0;
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.size_i = 2'b00; bus.addr_i = 32'h31;
    bus.wdata_i = 32'h55;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    checks++;
    if (bus.mem_read_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_read got mem_read=%b want 1", bus.mem_read_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy_o, bus.ack_o, bus.err_o, bus.mem_read_o, bus.mem_write_o, bus.rdata_o,
         bus.mem_addr_o, bus.mem_data_o} !== 101'b0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%b rd=%b wr=%b rdata=%h addr=%h data=%h want 0",
               bus.busy_o, bus.mem_read_o, bus.mem_write_o, bus.rdata_o, bus.mem_addr_o,
               bus.mem_data_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'h0;
    checks++;
    if (mem[32'h30 >> 2] !== want_word || ack_cnt !== 0 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL abort_mem got word=%h acks=%0d wr=%0d want %h 0 0", mem[32'h30 >> 2],
               ack_cnt, wr_cnt, want_word);
    end
    run(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 1'b0);
    checks++;
    if (got_rdata !== exp_rdata || got_lat !== 2 || got_err !== 1'b0) begin
      errors++;
      $display("FAIL after_abort got rdata=%h lat=%0d want %h 2", got_rdata, got_lat,
               exp_rdata);
    end
  endtask

  task automatic test_random();
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr;
    for (int it = 0; it < 80; it++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, MemBytes + 8));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      run(we, size, uns, addr, $urandom, 1'b0);
      checks++;
      if (got_rdata !== exp_rdata || got_err !== exp_err || got_lat !== exp_lat ||
          rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
        errors++;
        $display("FAIL rand_%0d we=%b sz=%0d a=%h got %h/%b/%0d/%0d/%0d want %h/%b/%0d/%0d/%0d",
                 it, we, size, addr, got_rdata, got_err, got_lat, rd_cnt, wr_cnt, exp_rdata,
                 exp_err, exp_lat, exp_rd, exp_wr);
      end
    end
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL strobe_overlap got %0d want 0", both_cnt);
    end
    for (int w = 0; w < 256; w++) begin
      checks++;
      if (mem[w] !== {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]}) begin
        errors++;
        $display("FAIL mem_word_%0d got %h want %h", w, mem[w],
                 {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]});
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00; bus.unsigned_i = 1'b0;
    bus.addr_i = 32'h0; bus.wdata_i = 32'h0;
    rd_cnt = 0; wr_cnt = 0; ack_cnt = 0; both_cnt = 0;
    model_rdata = 32'h0;
    for (int w = 0; w < 256; w++) begin
      v = $urandom;
      mem[w] = v;
      for (int b = 0; b < 4; b++) ref_bytes[4*w+b] = 8'(v >> (8 * b));
    end
    test_reset();
    test_word();
    test_byte_loads();
    test_subword_store();
    test_errors();
    test_busy_hold();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
